// File: rtl/univ_shift_reg.sv
// univ_shift_reg - parametrised universal register with a self-timed serial burst engine.
//
// Holds an N-bit word that can be loaded, shifted (logical/arithmetic), rotated or cleared
// under mode control, or shifted out LSB-first over N cycles as a serial burst.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   en            enables mode while idle
//   mode[2:0]     HOLD/LOAD/SHL/SHR/ROL/ROR/ASR/CLEAR
//   parallel_in   load data
//   sin_msb       bit entering the MSB on SHR and burst shifts
//   sin_lsb       bit entering the LSB on SHL
//   burst_start   launches an N-shift burst from idle
//   parallel_out  register contents
//   serial_out_l  parallel_out[N-1]
//   serial_out_r  parallel_out[0], the burst serial stream
//   busy          burst in progress
//   done          one-cycle pulse after the final burst shift
//   parity_out    registered ^parallel_out (only when PARITY_EN is defined)
//
// Build option: define PARITY_EN to add parity_out.
module univ_shift_reg #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] parallel_in,
  input  logic         sin_msb,
  input  logic         sin_lsb,
  input  logic         burst_start,
`ifdef PARITY_EN
  output logic         parity_out,
`endif
  output logic [N-1:0] parallel_out,
  output logic         serial_out_l,
  output logic         serial_out_r,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  state_t           state_q, state_d;
  logic [N-1:0]     q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;

  always_comb begin
    state_d = state_q;
    q_d     = q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // burst_start wins over any mode presented in the same cycle; the
        // launching edge only arms the counter, the word is untouched.
        if (burst_start) begin
          state_d = BURST;
          cnt_d   = CNT_W'(N);
        end else if (en) begin
          case (mode)
            M_HOLD:  q_d = q;
            M_LOAD:  q_d = parallel_in;
            M_SHL:   q_d = {q[N-2:0], sin_lsb};
            M_SHR:   q_d = {sin_msb, q[N-1:1]};
            M_ROL:   q_d = {q[N-2:0], q[N-1]};
            M_ROR:   q_d = {q[0], q[N-1:1]};
            M_ASR:   q_d = {q[N-1], q[N-1:1]};
            M_CLEAR: q_d = '0;
            default: q_d = q;
          endcase
        end
      end
      BURST: begin
        q_d   = {sin_msb, q[N-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q       <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
      cnt_q   <= cnt_d;
      done    <= done_d;
    end
  end

`ifdef PARITY_EN
  // Tracks the next register value so parity changes on the same edge as the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_out <= 1'b0;
    else        parity_out <= ^q_d;
  end
`endif

  assign busy         = (state_q == BURST);
  assign parallel_out = q;
  assign serial_out_l = q[N-1];
  assign serial_out_r = q[0];

endmodule
